dram_responder: RTL
===================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
- REQ-001: Parameters SHALL be: DW, default 8, data word width; AW, default 16, address width.
- REQ-002: Parameters SHALL also be: RD_WORDS, default 65536, words per read burst; WR_WORDS, default 16384, words per write burst; OUT_BASE, default 65536 mod 2^AW = 0, dmem base address of the result region.
- REQ-003: clk  in  1  single clock; all logic on the rising edge.
- REQ-004: reset  in  1  asynchronous, active-low reset; 0 = reset.
- REQ-005: rd_en, wr_en  in  1 each  level requests from state_control, each held high until its done pulse.
- REQ-006: rd_done, wr_done  out  1 each  one-cycle completion pulses.
- REQ-007: busy  out  1  high in any non-IDLE state.
- REQ-008: dram_addr  out  AW  DRAM word address.
- REQ-009: dram_re, dram_we  out  1 each  DRAM read and write strobes.
- REQ-010: dram_wdata  out  DW;  dram_rdata  in  DW, valid one cycle after dram_re.
- REQ-011: dmem_addr  out  AW;  dmem_we, dmem_re  out  1 each;  dmem_wdata  out  DW.
- REQ-012: dmem_rdata  in  DW, valid one cycle after dmem_re.

Function
- REQ-013: FSM states SHALL be: IDLE, RD_XFER, RD_DONE, WR_XFER, WR_DONE, ACK_WAIT.
- REQ-014: In IDLE with rd_en=1, next state SHALL be RD_XFER; with only wr_en=1, WR_XFER.
- REQ-015: When rd_en and wr_en are both high in IDLE, the read SHALL win and the write SHALL be served after ACK_WAIT if still requested.
- REQ-016: RD_XFER SHALL issue dram_re with dram_addr = 0 .. RD_WORDS-1, one address per cycle.
- REQ-017: RD_XFER SHALL write each returned word one cycle after issue: dmem_we=1, dmem_addr = issued address, dmem_wdata = dram_rdata.
- REQ-018: WR_XFER SHALL issue dmem_re at OUT_BASE+i for i = 0 .. WR_WORDS-1.
- REQ-019: WR_XFER SHALL write each returned word one cycle after issue: dram_we=1, dram_addr = i, dram_wdata = dmem_rdata.
- REQ-020: Throughput SHALL be one word per cycle with no bubbles.
- REQ-021: The transfer SHALL leave its XFER state the cycle after the last write, entering RD_DONE or WR_DONE.
- REQ-022: RD_DONE and WR_DONE SHALL each last exactly one cycle, asserting rd_done or wr_done respectively, then go to ACK_WAIT.
- REQ-023: Latency SHALL be: request sampled at edge 0; first strobe in cycle 1; done in cycle N+2, where N = burst length.
- REQ-024: ACK_WAIT SHALL return to IDLE only when rd_en=0 and wr_en=0, so no request is served twice.
- REQ-025: Deassertion of rd_en or wr_en during an XFER state SHALL be ignored; the burst completes and done still pulses.
- REQ-026: The address counter SHALL be AW+1 bits so a burst of 2^AW words terminates.
- REQ-027: dmem addresses SHALL wrap modulo 2^AW when OUT_BASE+i overflows.
- REQ-028: dram_we and dmem_we SHALL never be high in the same cycle.
- REQ-029: All strobes SHALL be 0 outside XFER states, except the final pipelined write in the cycle after the last issue.
- REQ-030: RD_WORDS=0 or WR_WORDS=0 SHALL go directly to the matching DONE state without strobes.

Reset
- REQ-031: reset=0 SHALL immediately force IDLE; counters, address, data outputs, strobes, busy, rd_done and wr_done all 0.
- REQ-032: Reset asserted mid-burst SHALL abort the burst without a done pulse; after release the FSM SHALL wait in IDLE for a fresh request.

Verification
- REQ-033: With RD_WORDS=4 and DRAM holding A0..A3, pulse rd_en high -> dram_re on addresses 0-3 in cycles 1-4, dmem_we writes A0..A3 in cycles 2-5, rd_done in cycle 6 only.
- REQ-034: With WR_WORDS=2, OUT_BASE=8 and dmem[8..9]=5A,C3, raise wr_en -> dmem_re on 8 and 9, then dram_we writes 5A to address 0 and C3 to address 1, then one wr_done pulse.
- REQ-035: rd_en and wr_en raised in the same cycle -> read burst and rd_done first; with wr_en still high, the write starts only after both requests drop.
- REQ-036: rd_en held high for 10 cycles after rd_done -> FSM stays in ACK_WAIT, no second burst, busy=1 until rd_en falls.
- REQ-037: reset pulled low in cycle 2 of a read burst -> all outputs 0 asynchronously, no rd_done; after release a new rd_en completes a full burst.
- REQ-038: RD_WORDS=2^AW (AW=4, 16 words) -> exactly 16 reads, counter terminates, rd_done once.

Source files
------------

// File: rtl/dram_responder_if.sv
// DRAM/dmem burst-mover bus bundle: request/done handshake plus both memory ports.
// master = the responder driving both memories; slave = controller and memories.
interface dram_responder_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic          rd_en;
  logic          wr_en;
  logic          rd_done;
  logic          wr_done;
  logic          busy;
  logic [AW-1:0] dram_addr;
  logic          dram_re;
  logic          dram_we;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] dram_rdata;
  logic [AW-1:0] dmem_addr;
  logic          dmem_we;
  logic          dmem_re;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;

  modport master (
    input  rd_en, wr_en, dram_rdata, dmem_rdata,
    output rd_done, wr_done, busy,
    output dram_addr, dram_re, dram_we, dram_wdata,
    output dmem_addr, dmem_we, dmem_re, dmem_wdata
  );

  modport slave (
    output rd_en, wr_en, dram_rdata, dmem_rdata,
    input  rd_done, wr_done, busy,
    input  dram_addr, dram_re, dram_we, dram_wdata,
    input  dmem_addr, dmem_we, dmem_re, dmem_wdata
  );
endinterface

// File: rtl/dram_responder.sv
// Moves a read burst DRAM->dmem or a write burst dmem->DRAM, one word per cycle.
// Done pulses N+2 cycles after the request edge; requests must drop before the next is taken.
module dram_responder #(
  parameter int DW       = 8,
  parameter int AW       = 16,
  parameter int RD_WORDS = 65536,
  parameter int WR_WORDS = 16384,
  parameter int OUT_BASE = 65536
) (
  input  logic              clk,
  input  logic              reset,
  dram_responder_if.master  bus
);

  localparam logic [AW:0]   RD_N = (AW+1)'(RD_WORDS);
  localparam logic [AW:0]   WR_N = (AW+1)'(WR_WORDS);
  localparam logic [AW-1:0] BASE = AW'(OUT_BASE);

  typedef enum logic [2:0] {
    IDLE, RD_XFER, RD_DONE, WR_XFER, WR_DONE, ACK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    paddr_d = paddr_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Read wins a tie; the write is re-taken only after a full ACK_WAIT release.
        if (bus.rd_en)      state_d = (RD_N == '0) ? RD_DONE : RD_XFER;
        else if (bus.wr_en) state_d = (WR_N == '0) ? WR_DONE : WR_XFER;
      end
      RD_XFER: begin
        if (cnt_q == RD_N) state_d = RD_DONE;
        else               issue   = 1'b1;
      end
      WR_XFER: begin
        if (cnt_q == WR_N) state_d = WR_DONE;
        else               issue   = 1'b1;
      end
      RD_DONE, WR_DONE: state_d = ACK_WAIT;
      ACK_WAIT: if (!bus.rd_en && !bus.wr_en) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (issue) begin
      cnt_d   = cnt_q + 1'b1;
      pend_d  = 1'b1;
      paddr_d = cnt_q[AW-1:0];
    end
  end

  // pend_q marks the write half of the pipeline: data returned for last cycle's issue.
  logic rd_mode, wr_mode;
  assign rd_mode = (state_q == RD_XFER);
  assign wr_mode = (state_q == WR_XFER);

  assign bus.dram_re    = issue & rd_mode;
  assign bus.dram_we    = pend_q & wr_mode;
  assign bus.dram_addr  = bus.dram_re ? cnt_q[AW-1:0] : (bus.dram_we ? paddr_q : '0);
  assign bus.dram_wdata = bus.dram_we ? bus.dmem_rdata : '0;

  assign bus.dmem_re    = issue & wr_mode;
  assign bus.dmem_we    = pend_q & rd_mode;
  assign bus.dmem_addr  = bus.dmem_re ? (BASE + cnt_q[AW-1:0]) : (bus.dmem_we ? paddr_q : '0);
  assign bus.dmem_wdata = bus.dmem_we ? bus.dram_rdata : '0;

  assign bus.busy    = (state_q != IDLE);
  assign bus.rd_done = (state_q == RD_DONE);
  assign bus.wr_done = (state_q == WR_DONE);

endmodule
